// File: rtl/fifo_flagged.sv
// fifo_flagged: parametrised synchronous FIFO with a live fill count,
// almost-full/almost-empty flags, sticky overflow/underflow flags and a
// selectable registered or first-word-fall-through read port.
module fifo_flagged #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int AF_THRESH  = FIFO_DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 WR_CMD,
  input  logic [FIFO_WIDTH-1:0]                WR_DATA,
  output logic                                 FIFO_FULL,
  output logic                                 ALMOST_FULL,
  input  logic                                 RD_CMD,
  output logic [FIFO_WIDTH-1:0]                RD_DATA,
  output logic                                 RD_VALID,
  output logic                                 FIFO_EMPTY,
  output logic                                 ALMOST_EMPTY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      FILL_COUNT,
  output logic                                 OVERFLOW,
  output logic                                 UNDERFLOW,
  input  logic                                 CLEAR_ERR
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_udf;

  logic                  w_rd_acc, w_wr_acc;
  logic [CW-1:0]         w_count_nxt;
  logic [PW-1:0]         w_wptr_nxt, w_rptr_nxt;

  // Accept decisions use the pre-edge count; a full FIFO still takes a
  // write when a read frees a slot on the same edge. No empty bypass.
  assign w_rd_acc    = RD_CMD && (r_count != '0);
  assign w_wr_acc    = WR_CMD && ((r_count != CW'(FIFO_DEPTH)) || w_rd_acc);
  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
  // Explicit wrap so non-power-of-two depths work.
  assign w_wptr_nxt  = (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt  = (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  // Storage write; contents survive reset, but a write coinciding with reset is dropped.
  always_ff @(posedge CLK) begin
    if (!RESET && w_wr_acc) r_mem[r_wptr] <= WR_DATA;
  end

  // Pointers, count and level flags; flags are derived from the post-edge count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
    end else begin
      if (w_wr_acc) r_wptr <= w_wptr_nxt;
      if (w_rd_acc) r_rptr <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= CW'(AF_THRESH));
      r_ae    <= (w_count_nxt <= CW'(AE_THRESH));
    end
  end

  // Sticky error flags; a new error on the clear edge wins over the clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (WR_CMD && !w_wr_acc) r_ovf <= 1'b1;
      else if (CLEAR_ERR)      r_ovf <= 1'b0;
      if (RD_CMD && !w_rd_acc) r_udf <= 1'b1;
      else if (CLEAR_ERR)      r_udf <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry shown directly; forced to zero while empty so reset reads back 0.
      assign RD_DATA  = r_empty ? '0 : r_mem[r_rptr];
      assign RD_VALID = !r_empty;
    end else begin : g_reg
      logic [FIFO_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;
      // Registered read port: load head on an accepted read, hold otherwise.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= r_mem[r_rptr];
        end
      end
      assign RD_DATA  = r_rd_data;
      assign RD_VALID = r_rd_valid;
    end
  endgenerate

  assign FIFO_FULL    = r_full;
  assign FIFO_EMPTY   = r_empty;
  assign ALMOST_FULL  = r_af;
  assign ALMOST_EMPTY = r_ae;
  assign FILL_COUNT   = r_count;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_udf;

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: default registered-read instance (a_),
// default FWFT instance (b_) and a depth-5 instance (c_) driven randomly
// against a queue model.
module tb_fifo_flagged;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance A: defaults, FWFT=0
  logic a_wr, a_rd, a_clr;
  logic [31:0] a_wd, a_rdata;
  logic a_full, a_af, a_empty, a_ae, a_vld, a_ovf, a_udf;
  logic [5:0] a_cnt;
  // instance B: defaults, FWFT=1
  logic b_wr, b_rd, b_clr;
  logic [31:0] b_wd, b_rdata;
  logic b_full, b_af, b_empty, b_ae, b_vld, b_ovf, b_udf;
  logic [5:0] b_cnt;
  // instance C: depth 5, FWFT=0
  logic c_wr, c_rd, c_clr;
  logic [7:0] c_wd, c_rdata;
  logic c_full, c_af, c_empty, c_ae, c_vld, c_ovf, c_udf;
  logic [2:0] c_cnt;

  fifo_flagged #(.FIFO_WIDTH(32), .FIFO_DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(0)) u_a (
    .CLK(clk), .RESET(rst), .WR_CMD(a_wr), .WR_DATA(a_wd), .FIFO_FULL(a_full),
    .ALMOST_FULL(a_af), .RD_CMD(a_rd), .RD_DATA(a_rdata), .RD_VALID(a_vld),
    .FIFO_EMPTY(a_empty), .ALMOST_EMPTY(a_ae), .FILL_COUNT(a_cnt),
    .OVERFLOW(a_ovf), .UNDERFLOW(a_udf), .CLEAR_ERR(a_clr));

  fifo_flagged #(.FIFO_WIDTH(32), .FIFO_DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1)) u_b (
    .CLK(clk), .RESET(rst), .WR_CMD(b_wr), .WR_DATA(b_wd), .FIFO_FULL(b_full),
    .ALMOST_FULL(b_af), .RD_CMD(b_rd), .RD_DATA(b_rdata), .RD_VALID(b_vld),
    .FIFO_EMPTY(b_empty), .ALMOST_EMPTY(b_ae), .FILL_COUNT(b_cnt),
    .OVERFLOW(b_ovf), .UNDERFLOW(b_udf), .CLEAR_ERR(b_clr));

  fifo_flagged #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_c (
    .CLK(clk), .RESET(rst), .WR_CMD(c_wr), .WR_DATA(c_wd), .FIFO_FULL(c_full),
    .ALMOST_FULL(c_af), .RD_CMD(c_rd), .RD_DATA(c_rdata), .RD_VALID(c_vld),
    .FIFO_EMPTY(c_empty), .ALMOST_EMPTY(c_ae), .FILL_COUNT(c_cnt),
    .OVERFLOW(c_ovf), .UNDERFLOW(c_udf), .CLEAR_ERR(c_clr));

  // advance one edge, then sample away from it
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_cmp++; if (a_cnt !== 6'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", a_cnt); end
    n_cmp++; if ({a_empty, a_ae, a_full, a_af} !== 4'b1100) begin n_err++; $display("FAIL rst_lvl got %b exp 1100", {a_empty, a_ae, a_full, a_af}); end
    n_cmp++; if ({a_vld, a_ovf, a_udf} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b exp 000", {a_vld, a_ovf, a_udf}); end
    n_cmp++; if (a_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %0h exp 0", a_rdata); end
    n_cmp++; if ({b_rdata, b_vld} !== 33'd0) begin n_err++; $display("FAIL rst_fwft got %0h/%b exp 0/0", b_rdata, b_vld); end
    n_cmp++; if ({c_cnt, c_empty, c_ae, c_full, c_af} !== 7'b000_1100) begin n_err++; $display("FAIL rst_c got %b exp 0001100", {c_cnt, c_empty, c_ae, c_full, c_af}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 32; i++) begin
      a_wr = 1'b1; a_wd = 32'(i); step();
      n_cmp++; if (a_cnt !== 6'(i)) begin n_err++; $display("FAIL fill_cnt[%0d] got %0d exp %0d", i, a_cnt, i); end
      n_cmp++; if (a_af !== (i >= 28)) begin n_err++; $display("FAIL fill_af[%0d] got %b exp %b", i, a_af, (i >= 28)); end
      n_cmp++; if (a_full !== (i == 32)) begin n_err++; $display("FAIL fill_full[%0d] got %b exp %b", i, a_full, (i == 32)); end
    end
    a_wd = 32'd33; step(); a_wr = 1'b0;
    n_cmp++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", a_ovf); end
    n_cmp++; if (a_cnt !== 6'd32) begin n_err++; $display("FAIL ovf_cnt got %0d exp 32", a_cnt); end
    a_rd = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      n_cmp++; if ({a_vld, a_rdata} !== {1'b1, 32'(i)}) begin n_err++; $display("FAIL drain[%0d] got %b/%0d exp 1/%0d", i, a_vld, a_rdata, i); end
    end
    a_rd = 1'b0; step();
    n_cmp++; if ({a_empty, a_ae, a_vld, a_cnt} !== {3'b110, 6'd0}) begin n_err++; $display("FAIL drained got %b/%0d exp 110/0", {a_empty, a_ae, a_vld}, a_cnt); end
    a_clr = 1'b1; step(); a_clr = 1'b0;
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b exp 0", a_ovf); end
  endtask

  task automatic test_underflow();
    a_rd = 1'b1; step(); a_rd = 1'b0;
    n_cmp++; if ({a_udf, a_empty, a_vld} !== 3'b110) begin n_err++; $display("FAIL udf_set got %b exp 110", {a_udf, a_empty, a_vld}); end
    n_cmp++; if (a_rdata !== 32'd32) begin n_err++; $display("FAIL udf_hold got %0d exp 32", a_rdata); end
    a_clr = 1'b1; step();
    n_cmp++; if (a_udf !== 1'b0) begin n_err++; $display("FAIL udf_clr got %b exp 0", a_udf); end
    a_rd = 1'b1; step(); a_rd = 1'b0; a_clr = 1'b0;
    n_cmp++; if (a_udf !== 1'b1) begin n_err++; $display("FAIL udf_setwins got %b exp 1", a_udf); end
    a_clr = 1'b1; step(); a_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp;
    for (int i = 1; i <= 32; i++) begin
      a_wr = 1'b1; a_wd = 32'(i + 500); q.push_back(32'(i + 500)); step();
    end
    n_cmp++; if (a_full !== 1'b1) begin n_err++; $display("FAIL b2b_full got %b exp 1", a_full); end
    a_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a_wd = 32'(1000 + i);
      exp = q.pop_front(); q.push_back(a_wd);
      step();
      n_cmp++; if ({a_vld, a_rdata} !== {1'b1, exp}) begin n_err++; $display("FAIL b2b_data[%0d] got %b/%0d exp 1/%0d", i, a_vld, a_rdata, exp); end
      n_cmp++; if ({a_cnt, a_full, a_ovf} !== {6'd32, 2'b10}) begin n_err++; $display("FAIL b2b_lvl[%0d] got %0d/%b%b exp 32/10", i, a_cnt, a_full, a_ovf); end
    end
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  task automatic test_empty_simul();
    rst = 1'b1; step(); rst = 1'b0;
    a_rd = 1'b1; a_wr = 1'b1; a_wd = 32'hA5;
    b_rd = 1'b1; b_wr = 1'b1; b_wd = 32'hA5;
    step();
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    n_cmp++; if ({a_udf, a_cnt} !== {1'b1, 6'd1}) begin n_err++; $display("FAIL es_a got %b/%0d exp 1/1", a_udf, a_cnt); end
    n_cmp++; if ({b_udf, b_cnt} !== {1'b1, 6'd1}) begin n_err++; $display("FAIL es_b got %b/%0d exp 1/1", b_udf, b_cnt); end
    n_cmp++; if ({b_vld, b_rdata} !== {1'b1, 32'hA5}) begin n_err++; $display("FAIL es_fwft got %b/%0h exp 1/a5", b_vld, b_rdata); end
    // FWFT read consumes the head: valid drops, data returns to zero
    b_rd = 1'b1; step(); b_rd = 1'b0;
    n_cmp++; if ({b_vld, b_empty, b_cnt} !== {2'b01, 6'd0}) begin n_err++; $display("FAIL fwft_pop got %b%b/%0d exp 01/0", b_vld, b_empty, b_cnt); end
  endtask

  task automatic test_reset_mid();
    a_clr = 1'b1; a_wr = 1'b1;
    for (int i = 0; i < 9; i++) begin a_wd = 32'(i + 7); step(); a_clr = 1'b0; end
    a_wr = 1'b0;
    n_cmp++; if (a_cnt !== 6'd10) begin n_err++; $display("FAIL rm_pre got %0d exp 10", a_cnt); end
    a_rd = 1'b1; step();
    n_cmp++; if ({a_vld, a_rdata} !== {1'b1, 32'hA5}) begin n_err++; $display("FAIL rm_head got %b/%0h exp 1/a5", a_vld, a_rdata); end
    a_rd = 1'b0; a_wr = 1'b1; a_wd = 32'd77; rst = 1'b1; step(); rst = 1'b0; a_wr = 1'b0;
    n_cmp++; if ({a_cnt, a_empty, a_ae, a_full, a_af} !== {6'd0, 4'b1100}) begin n_err++; $display("FAIL rm_lvl got %0d/%b exp 0/1100", a_cnt, {a_empty, a_ae, a_full, a_af}); end
    n_cmp++; if ({a_rdata, a_vld, a_ovf, a_udf} !== 35'd0) begin n_err++; $display("FAIL rm_out got %0h/%b exp 0/000", a_rdata, {a_vld, a_ovf, a_udf}); end
    step();
    n_cmp++; if (a_cnt !== 6'd0) begin n_err++; $display("FAIL rm_discard got %0d exp 0", a_cnt); end
  endtask

  task automatic test_random_depth5();
    logic [7:0] q[$];
    logic [7:0] exp_data = 8'd0;
    logic exp_vld, rd_acc, wr_acc;
    int sz;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      c_rd = 1'($urandom_range(0, 1));
      c_wr = 1'($urandom_range(0, 1));
      c_wd = 8'($urandom);
      rd_acc = c_rd && (q.size() > 0);
      wr_acc = c_wr && ((q.size() < 5) || rd_acc);
      exp_vld = rd_acc;
      if (rd_acc) exp_data = q.pop_front();
      if (wr_acc) q.push_back(c_wd);
      sz = q.size();
      step();
      n_cmp++; if ({c_vld, c_rdata} !== {exp_vld, exp_data}) begin n_err++; $display("FAIL rnd_data[%0d] got %b/%0h exp %b/%0h", cyc, c_vld, c_rdata, exp_vld, exp_data); end
      n_cmp++; if (c_cnt !== 3'(sz)) begin n_err++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", cyc, c_cnt, sz); end
      n_cmp++; if ({c_full, c_af, c_empty, c_ae} !== {sz == 5, sz >= 4, sz == 0, sz <= 1}) begin n_err++; $display("FAIL rnd_lvl[%0d] got %b exp %b", cyc, {c_full, c_af, c_empty, c_ae}, {sz == 5, sz >= 4, sz == 0, sz <= 1}); end
    end
    c_rd = 1'b0; c_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {a_wr, a_rd, a_clr, b_wr, b_rd, b_clr, c_wr, c_rd, c_clr} = '0;
    a_wd = '0; b_wd = '0; c_wd = '0;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_empty_simul();
    test_reset_mid();
    test_random_depth5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
